// File: rtl/grid_pkg.sv
// Shared definitions for the grid movement path: direction codes, engine states,
// sizing helper and the default map geometry also used by the renderer.
package grid_pkg;

  localparam int MAP_W_DEF = 20;
  localparam int MAP_H_DEF = 15;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_LOOK,
    ST_COMMIT
  } move_state_e;

  // Never returns 0 so that single-entry parameters still get a 1-bit select.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wall_map_ram.sv
// Multi-map wall memory: one row per word, synchronous write, registered read.
// Contents survive reset; power-up image has walls on every map border.
module wall_map_ram
  import grid_pkg::*;
#(
  parameter int MAP_W    = MAP_W_DEF,
  parameter int MAP_H    = MAP_H_DEF,
  parameter int NUM_MAPS = 4,
  localparam int MW = clog2(NUM_MAPS),
  localparam int YW = clog2(MAP_H)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [MW-1:0]    wr_map_i,
  input  logic [YW-1:0]    wr_row_i,
  input  logic [MAP_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [MW-1:0]    rd_map_i,
  input  logic [YW-1:0]    rd_row_i,
  output logic [MAP_W-1:0] rd_data_o
);

  localparam int DEPTH = NUM_MAPS * MAP_H;
  localparam int AW    = clog2(DEPTH);

  typedef logic [DEPTH-1:0][MAP_W-1:0] mem_t;

  function automatic mem_t border_init();
    mem_t m;
    for (int a = 0; a < DEPTH; a++) begin
      if ((a % MAP_H == 0) || (a % MAP_H == MAP_H - 1)) begin
        m[AW'(a)] = '1;
      end else begin
        m[AW'(a)]          = '0;
        m[AW'(a)][0]       = 1'b1;
        m[AW'(a)][MAP_W-1] = 1'b1;
      end
    end
    return m;
  endfunction

  mem_t             mem_q = border_init();
  logic [MAP_W-1:0] rd_data_q;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             wr_ok, rd_ok;

  always_comb begin
    wr_ok   = (int'(wr_map_i) < NUM_MAPS) && (int'(wr_row_i) < MAP_H);
    rd_ok   = (int'(rd_map_i) < NUM_MAPS) && (int'(rd_row_i) < MAP_H);
    wr_addr = AW'(int'(wr_map_i) * MAP_H + int'(wr_row_i));
    rd_addr = rd_ok ? AW'(int'(rd_map_i) * MAP_H + int'(rd_row_i)) : '0;
  end

  // Non-blocking update gives read-before-write on a same-row collision.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_ok) mem_q[wr_addr] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/grid_move_engine.sv
// Clocked move engine: owns player positions, checks each requested step against
// map bounds and the wall memory, commits or rejects it, and pulses a result.
module grid_move_engine
  import grid_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int NUM_MAPS    = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 6,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  localparam int MW = clog2(NUM_MAPS),
  localparam int PW = clog2(NUM_PLAYERS),
  localparam int YW = clog2(MAP_H)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MW-1:0]                map_sel,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [PW-1:0]                req_player,
  input  logic [1:0]                   req_dir,
  input  logic                         wr_en,
  input  logic [MW-1:0]                wr_map,
  input  logic [YW-1:0]                wr_row,
  input  logic [MAP_W-1:0]             wr_data,
  output logic                         done_valid,
  output logic [PW-1:0]                done_player,
  output logic                         done_blocked,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_x,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_y
);

  localparam int XW = clog2(MAP_W);
  localparam logic signed [POS_W:0] ONE   = (POS_W+1)'(1);
  localparam logic signed [POS_W:0] LIM_X = (POS_W+1)'(MAP_W);
  localparam logic signed [POS_W:0] LIM_Y = (POS_W+1)'(MAP_H);

  move_state_e state_q, state_d;

  logic [PW-1:0]          player_q;
  logic [1:0]             dir_q;
  logic [MW-1:0]          map_q;
  logic                   bad_q, req_bad;
  logic [POS_W-1:0]       cur_x_q, cur_y_q;
  logic signed [POS_W:0]  cx, cy, tx_d, ty_d;
  logic [POS_W-1:0]       tx_q, ty_q;
  logic                   oob_d, oob_q, blocked_d, blocked_q;
  logic [POS_W-1:0]       pos_x_q [NUM_PLAYERS];
  logic [POS_W-1:0]       pos_y_q [NUM_PLAYERS];
  logic                   done_valid_q, done_blocked_q;
  logic [PW-1:0]          done_player_q;
  logic                   rd_en;
  logic [YW-1:0]          rd_row;
  logic [MAP_W-1:0]       rd_data;

  wall_map_ram #(
    .MAP_W    (MAP_W),
    .MAP_H    (MAP_H),
    .NUM_MAPS (NUM_MAPS)
  ) u_wall_map_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_map_i  (wr_map),
    .wr_row_i  (wr_row),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_map_i  (map_q),
    .rd_row_i  (rd_row),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        rd_en   = 1'b1;
        state_d = ST_LOOK;
      end
      ST_LOOK:   state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Target is one bit wider than a coordinate so a step off x=0 / y=0 goes negative.
  always_comb begin
    cx   = $signed({1'b0, cur_x_q});
    cy   = $signed({1'b0, cur_y_q});
    tx_d = cx;
    ty_d = cy;
    case (dir_q)
      DIR_RIGHT: tx_d = cx + ONE;
      DIR_UP:    ty_d = cy - ONE;
      DIR_LEFT:  tx_d = cx - ONE;
      default:   ty_d = cy + ONE;
    endcase
    oob_d     = tx_d[POS_W] || ty_d[POS_W] || (tx_d >= LIM_X) || (ty_d >= LIM_Y);
    rd_row    = oob_d ? '0 : ty_d[YW-1:0];
    req_bad   = (int'(req_player) >= NUM_PLAYERS) || (int'(map_sel) >= NUM_MAPS);
    blocked_d = bad_q || oob_q || rd_data[tx_q[XW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        pos_x_q[p] <= POS_W'(START_X);
        pos_y_q[p] <= POS_W'(START_Y);
      end
      player_q       <= '0;
      dir_q          <= DIR_RIGHT;
      map_q          <= '0;
      bad_q          <= 1'b0;
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      tx_q           <= '0;
      ty_q           <= '0;
      oob_q          <= 1'b0;
      blocked_q      <= 1'b0;
      done_valid_q   <= 1'b0;
      done_player_q  <= '0;
      done_blocked_q <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            player_q <= req_player;
            dir_q    <= req_dir;
            map_q    <= map_sel;
            bad_q    <= req_bad;
            cur_x_q  <= req_bad ? '0 : pos_x_q[req_player];
            cur_y_q  <= req_bad ? '0 : pos_y_q[req_player];
          end
        end
        ST_CALC: begin
          tx_q  <= tx_d[POS_W-1:0];
          ty_q  <= ty_d[POS_W-1:0];
          oob_q <= oob_d;
        end
        ST_LOOK: blocked_q <= blocked_d;
        ST_COMMIT: begin
          // A bad player index always sets blocked, so the write index is valid here.
          if (!blocked_q) begin
            pos_x_q[player_q] <= tx_q;
            pos_y_q[player_q] <= ty_q;
          end
          done_valid_q   <= 1'b1;
          done_player_q  <= player_q;
          done_blocked_q <= blocked_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pos_x[p*POS_W +: POS_W] = pos_x_q[p];
      pos_y[p*POS_W +: POS_W] = pos_y_q[p];
    end
  end

  assign done_valid   = done_valid_q;
  assign done_player  = done_player_q;
  assign done_blocked = done_blocked_q;

endmodule

// File: tb/tb_grid_move_engine.sv
// Directed bench for grid_move_engine: a small map/position model predicts each
// move result, which is queued on accept and checked against the done pulse.
module tb_grid_move_engine;
  import grid_pkg::*;

  localparam int MAP_W       = 20;
  localparam int MAP_H       = 15;
  localparam int NUM_MAPS    = 4;
  localparam int NUM_PLAYERS = 2;
  localparam int POS_W       = 6;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [1:0]                   map_sel = '0;
  logic                         req_valid = 1'b0;
  logic                         req_ready;
  logic [0:0]                   req_player = '0;
  logic [1:0]                   req_dir = '0;
  logic                         wr_en = 1'b0;
  logic [1:0]                   wr_map = '0;
  logic [3:0]                   wr_row = '0;
  logic [MAP_W-1:0]             wr_data = '0;
  logic                         done_valid;
  logic [0:0]                   done_player;
  logic                         done_blocked;
  logic [NUM_PLAYERS*POS_W-1:0] pos_x, pos_y;

  grid_move_engine #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_MAPS(NUM_MAPS), .NUM_PLAYERS(NUM_PLAYERS),
    .POS_W(POS_W), .START_X(1), .START_Y(1)
  ) dut (
    .clk(clk), .reset(reset), .map_sel(map_sel), .req_valid(req_valid),
    .req_ready(req_ready), .req_player(req_player), .req_dir(req_dir),
    .wr_en(wr_en), .wr_map(wr_map), .wr_row(wr_row), .wr_data(wr_data),
    .done_valid(done_valid), .done_player(done_player), .done_blocked(done_blocked),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int player;
    int blocked;
    int acceptCycle;
    int x0, y0, x1, y1;
  } exp_t;

  exp_t             expQ[$];
  int               accCycles[$];
  int               testsRun = 0;
  int               testsFailed = 0;
  int               modelX[NUM_PLAYERS];
  int               modelY[NUM_PLAYERS];
  logic [MAP_W-1:0] modelWall[NUM_MAPS][MAP_H];

  function automatic int getX(input int p);
    return int'(pos_x[p*POS_W +: POS_W]);
  endfunction

  function automatic int getY(input int p);
    return int'(pos_y[p*POS_W +: POS_W]);
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model of one move: bounds first, then the wall bit of the selected map.
  task automatic pushExpect(input int p, input int d, input int m, input int acc);
    exp_t e;
    int   nx, ny;
    nx = modelX[p];
    ny = modelY[p];
    case (d)
      0:       nx = nx + 1;
      1:       ny = ny - 1;
      2:       nx = nx - 1;
      default: ny = ny + 1;
    endcase
    e.blocked = 0;
    if (nx < 0 || ny < 0 || nx >= MAP_W || ny >= MAP_H) e.blocked = 1;
    else if (modelWall[m][ny][nx]) e.blocked = 1;
    if (e.blocked == 0) begin
      modelX[p] = nx;
      modelY[p] = ny;
    end
    e.player      = p;
    e.acceptCycle = acc;
    e.x0 = modelX[0]; e.y0 = modelY[0];
    e.x1 = modelX[1]; e.y1 = modelY[1];
    expQ.push_back(e);
  endtask

  // Called on a falling edge with the engine idle; returns one cycle later (engine in CALC).
  task automatic applyStimulus(input string tag, input int p, input int d, input int m);
    compare({tag, "_ready"}, 32'(req_ready), 1);
    pushExpect(p, d, m, cycle + 1);
    req_player = 1'(p);
    req_dir    = 2'(d);
    map_sel    = 2'(m);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic writeRow(input int m, input int r, input logic [MAP_W-1:0] data);
    wr_map  = 2'(m);
    wr_row  = 4'(r);
    wr_data = data;
    wr_en   = 1'b1;
    if (m < NUM_MAPS && r < MAP_H) modelWall[m][r] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic checkDone(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      compare({tag, "_unexpected_done"}, 32'(expQ.size()), 1);
      return;
    end
    e = expQ.pop_front();
    compare({tag, "_latency"}, 32'(cycle), 32'(e.acceptCycle + 3));
    compare({tag, "_player"},  32'(done_player), 32'(e.player));
    compare({tag, "_blocked"}, 32'(done_blocked), 32'(e.blocked));
    compare({tag, "_x0"}, 32'(getX(0)), 32'(e.x0));
    compare({tag, "_y0"}, 32'(getY(0)), 32'(e.y0));
    compare({tag, "_x1"}, 32'(getX(1)), 32'(e.x1));
    compare({tag, "_y1"}, 32'(getY(1)), 32'(e.y1));
  endtask

  task automatic checkOutput(input string tag);
    int waitCnt;
    waitCnt = 0;
    while (!done_valid && waitCnt < 8) begin
      @(negedge clk);
      waitCnt++;
    end
    if (done_valid !== 1'b1) begin
      compare({tag, "_done_timeout"}, 32'(done_valid), 1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      checkDone(tag);
    end
  endtask

  initial begin
    int accepts;

    for (int m = 0; m < NUM_MAPS; m++)
      for (int r = 0; r < MAP_H; r++)
        modelWall[m][r] = (r == 0 || r == MAP_H - 1) ? '1 : {1'b1, {(MAP_W-2){1'b0}}, 1'b1};
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      modelX[p] = 1;
      modelY[p] = 1;
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    compare("rst_ready",        32'(req_ready), 1);
    compare("rst_done_valid",   32'(done_valid), 0);
    compare("rst_done_player",  32'(done_player), 0);
    compare("rst_done_blocked", 32'(done_blocked), 0);
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      compare("rst_pos_x", 32'(getX(p)), 1);
      compare("rst_pos_y", 32'(getY(p)), 1);
    end
    @(negedge clk);

    applyStimulus("p0_right", 0, DIR_RIGHT, 0);
    checkOutput("p0_right");
    compare("p0_right_x_const", 32'(getX(0)), 2);
    applyStimulus("p0_left", 0, DIR_LEFT, 0);
    checkOutput("p0_left");
    applyStimulus("p0_up_wall", 0, DIR_UP, 0);
    checkOutput("p0_up_wall");
    compare("p0_up_y_const", 32'(getY(0)), 1);

    writeRow(2, 1, 20'h00008);
    applyStimulus("p1_m2_right", 1, DIR_RIGHT, 2);
    checkOutput("p1_m2_right");
    applyStimulus("p1_m2_wall", 1, DIR_RIGHT, 2);
    checkOutput("p1_m2_wall");
    applyStimulus("p1_m0_right", 1, DIR_RIGHT, 0);
    checkOutput("p1_m0_right");
    compare("p1_m0_x_const", 32'(getX(1)), 3);

    // Row 15 does not exist; if it aliased into map 1 row 0 the up move would pass.
    writeRow(0, 15, '0);
    applyStimulus("p1_m1_up", 1, DIR_UP, 1);
    checkOutput("p1_m1_up");

    writeRow(0, 1, '0);
    applyStimulus("p0_to_x0", 0, DIR_LEFT, 0);
    checkOutput("p0_to_x0");
    applyStimulus("p0_oob_left", 0, DIR_LEFT, 0);
    checkOutput("p0_oob_left");
    compare("p0_nowrap_const", 32'(getX(0)), 0);

    // Same-row write in the cycle the read is issued: the move sees the old row.
    applyStimulus("p0_rbw", 0, DIR_RIGHT, 0);
    writeRow(0, 1, 20'h00006);
    checkOutput("p0_rbw");
    applyStimulus("p0_new_wall", 0, DIR_RIGHT, 0);
    checkOutput("p0_new_wall");

    req_player = 1'b1;
    req_dir    = DIR_DOWN;
    map_sel    = 2'd0;
    req_valid  = 1'b1;
    accepts    = 0;
    accCycles.delete();
    for (int i = 0; i < 20 && (accepts < 3 || expQ.size() > 0); i++) begin
      if (req_valid && req_ready) begin
        pushExpect(1, DIR_DOWN, 0, cycle + 1);
        accCycles.push_back(cycle + 1);
        accepts++;
      end
      @(negedge clk);
      if (accepts == 3) req_valid = 1'b0;
      if (done_valid) checkDone("thru");
    end
    req_valid = 1'b0;
    compare("thru_accepts", 32'(accepts), 3);
    compare("thru_drained", 32'(expQ.size()), 0);
    if (accCycles.size() == 3) begin
      compare("thru_spacing1", 32'(accCycles[1] - accCycles[0]), 4);
      compare("thru_spacing2", 32'(accCycles[2] - accCycles[1]), 4);
    end

    applyStimulus("rst_abort", 1, DIR_RIGHT, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compare("abort_done_valid", 32'(done_valid), 0);
    compare("abort_ready",      32'(req_ready), 1);
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      compare("abort_pos_x", 32'(getX(p)), 1);
      compare("abort_pos_y", 32'(getY(p)), 1);
    end
    reset = 1'b0;
    @(negedge clk);
    compare("abort_no_late_done", 32'(done_valid), 0);
    expQ.delete();
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      modelX[p] = 1;
      modelY[p] = 1;
    end

    // Wall memory keeps the 0x6 row written before the reset.
    applyStimulus("post_rst_wall", 0, DIR_RIGHT, 0);
    checkOutput("post_rst_wall");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
